rr_decoder_arbiter: RTL and testbench

- Round-robin arbiter that shares one 2-to-4 decoder output path among four requesters.
- Drives the decoder select (sel) and enable (en) directly, plus a registered one-hot grant vector that is identical to the decoder output.
- Guarantees break-before-make: one dead cycle with en=0 between successive grants.
- Optional hold timeout forces rotation when other requesters are waiting.

---
 rtl/rr_decoder_arbiter_if.sv | 11 +
 rtl/rr_decoder_arbiter.sv | 121 ++++++++++++
 tb/tb_rr_decoder_arbiter.sv | 125 ++++++++++++
 3 files changed

// File: rtl/rr_decoder_arbiter_if.sv
// Request/grant bundle between four requesters and the shared 2-to-4 decoder path.
interface rr_decoder_arbiter_if;
   logic [3:0] req;
   logic [1:0] sel;
   logic       en;
   logic [3:0] gnt;
   logic       busy;

   modport master (input req, output sel, output en, output gnt, output busy);
   modport slave  (output req, input sel, input en, input gnt, input busy);
endinterface

// File: rtl/rr_decoder_arbiter.sv
// Round-robin owner of a shared 2-to-4 decoder path: one dead cycle between
// successive grants and an optional hold timeout when others are waiting.
module rr_decoder_arbiter #(
   parameter int unsigned MAX_HOLD = 8
) (
   input logic                  clk,
   input logic                  rst_n,
   rr_decoder_arbiter_if.master bus
);
   localparam int unsigned N_REQ = 4;
   localparam int unsigned SEL_W = 2;
   localparam int unsigned CNT_W = 8;
   localparam logic             TIMEOUT_EN = (MAX_HOLD != 0);
   localparam logic [CNT_W-1:0] HOLD_LIM   = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);
   localparam logic [CNT_W-1:0] HOLD_SAT   = '1;

   typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

   state_t             state_q, state_d;
   logic [SEL_W-1:0]   sel_q, sel_d;
   logic               en_q, en_d;
   logic [N_REQ-1:0]   gnt_q, gnt_d;
   logic               busy_q, busy_d;
   logic [SEL_W-1:0]   last_q, last_d;
   logic [CNT_W-1:0]   hold_q, hold_d;

   logic               win_vld_c;
   logic [SEL_W-1:0]   win_c;
   logic               others_c;

   // First requester after last, wrapping; last itself is checked last.
   always_comb begin
      logic [SEL_W-1:0] cand;
      win_vld_c = 1'b0;
      win_c     = last_q;
      cand      = last_q;
      for (int i = 1; i <= int'(N_REQ); i++) begin
         cand = last_q + SEL_W'(i);
         if (!win_vld_c && bus.req[cand]) begin
            win_vld_c = 1'b1;
            win_c     = cand;
         end
      end
   end

   assign others_c = |(bus.req & ~(N_REQ'(1) << sel_q));

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      en_d    = en_q;
      gnt_d   = gnt_q;
      busy_d  = busy_q;
      last_d  = last_q;
      hold_d  = hold_q;
      case (state_q)
         IDLE, GAP: begin
            if (win_vld_c) begin
               state_d = GRANT;
               sel_d   = win_c;
               en_d    = 1'b1;
               gnt_d   = N_REQ'(1) << win_c;
               busy_d  = 1'b1;
               last_d  = win_c;
               hold_d  = '0;
            end else begin
               state_d = IDLE;
               sel_d   = '0;
               en_d    = 1'b0;
               gnt_d   = '0;
               busy_d  = 1'b0;
               hold_d  = '0;
            end
         end
         GRANT: begin
            if (hold_q != HOLD_SAT) hold_d = hold_q + CNT_W'(1);
            // Owner release or timeout with contention both take the single dead cycle.
            if (!bus.req[sel_q] || (TIMEOUT_EN && (hold_q >= HOLD_LIM) && others_c)) begin
               state_d = GAP;
               en_d    = 1'b0;
               gnt_d   = '0;
               busy_d  = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            sel_d   = '0;
            en_d    = 1'b0;
            gnt_d   = '0;
            busy_d  = 1'b0;
            last_d  = SEL_W'(N_REQ - 1);
            hold_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sel_q   <= '0;
         en_q    <= 1'b0;
         gnt_q   <= '0;
         busy_q  <= 1'b0;
         last_q  <= SEL_W'(N_REQ - 1);
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         en_q    <= en_d;
         gnt_q   <= gnt_d;
         busy_q  <= busy_d;
         last_q  <= last_d;
         hold_q  <= hold_d;
      end
   end

   assign bus.sel  = sel_q;
   assign bus.en   = en_q;
   assign bus.gnt  = gnt_q;
   assign bus.busy = busy_q;
endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// Directed bench for rr_decoder_arbiter with MAX_HOLD=4; outputs sampled on falling edges.
module tb_rr_decoder_arbiter;
   logic clk;
   logic rst_n;
   int   tests_run;
   int   tests_failed;

   rr_decoder_arbiter_if bus ();

   rr_decoder_arbiter #(.MAX_HOLD(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int unsigned act, input int unsigned exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   initial begin
      logic [3:0] exp_gnt;
      tests_run    = 0;
      tests_failed = 0;
      rst_n        = 1'b0;
      bus.req      = 4'b1111;

      // Reset held with all requesting: everything stays quiet.
      repeat (2) begin
         @(negedge clk);
         check("rst_gnt",  32'(bus.gnt),  32'h0);
         check("rst_en",   32'(bus.en),   32'h0);
         check("rst_sel",  32'(bus.sel),  32'h0);
         check("rst_busy", 32'(bus.busy), 32'h0);
      end
      rst_n = 1'b1;

      // Rotation: 4 grant cycles then one dead cycle, period 5.
      for (int i = 0; i < 21; i++) begin
         @(negedge clk);
         exp_gnt = ((i % 5) == 4) ? 4'b0000 : (4'b0001 << ((i / 5) % 4));
         check("rot_gnt", 32'(bus.gnt), 32'(exp_gnt));
         if (i == 0) begin
            check("rot_first_sel", 32'(bus.sel), 32'h0);
            check("rot_first_en",  32'(bus.en),  32'h1);
         end
      end

      rst_n   = 1'b0;
      bus.req = 4'b0000;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_busy", 32'(bus.busy), 32'h0);

      // Single owner for 5 cycles, then GAP, then IDLE.
      bus.req = 4'b0100;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("single_gnt", 32'(bus.gnt), 32'h4);
      end
      bus.req = 4'b0000;
      @(negedge clk);
      check("single_gap_gnt",  32'(bus.gnt),  32'h0);
      check("single_gap_en",   32'(bus.en),   32'h0);
      check("single_gap_busy", 32'(bus.busy), 32'h1);
      check("single_gap_sel",  32'(bus.sel),  32'h2);
      @(negedge clk);
      check("single_idle_busy", 32'(bus.busy), 32'h0);

      // Fairness after owner 2 released: 3, then 0, then 1.
      bus.req = 4'b1011;
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         if (i < 4)       exp_gnt = 4'b1000;
         else if (i == 4) exp_gnt = 4'b0000;
         else if (i < 9)  exp_gnt = 4'b0001;
         else if (i == 9) exp_gnt = 4'b0000;
         else             exp_gnt = 4'b0010;
         check("fair_gnt", 32'(bus.gnt), 32'(exp_gnt));
      end
      bus.req = 4'b0000;
      repeat (2) @(negedge clk);
      check("fair_idle_busy", 32'(bus.busy), 32'h0);

      // Sole requester is never pre-empted by the timeout.
      bus.req = 4'b0010;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("sole_gnt", 32'(bus.gnt), 32'h2);
      end
      bus.req = 4'b1010;
      @(negedge clk);
      check("sole_gap_gnt",  32'(bus.gnt),  32'h0);
      check("sole_gap_busy", 32'(bus.busy), 32'h1);
      @(negedge clk);
      check("sole_next_gnt", 32'(bus.gnt), 32'h8);

      // Async reset while requester 2 owns the path.
      bus.req = 4'b0100;
      @(negedge clk);
      check("pre_rst_gap", 32'(bus.gnt), 32'h0);
      @(negedge clk);
      check("pre_rst_gnt", 32'(bus.gnt), 32'h4);
      #2 rst_n = 1'b0;
      #1;
      check("async_gnt",  32'(bus.gnt),  32'h0);
      check("async_en",   32'(bus.en),   32'h0);
      check("async_busy", 32'(bus.busy), 32'h0);
      bus.req = 4'b0101;
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_gnt", 32'(bus.gnt), 32'h1);
      check("post_rst_sel", 32'(bus.sel), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
